// File: rtl/arch_map_table_pkg.sv
// Shared sizing and FSM encoding for the commit-side architectural map table.
package arch_map_table_pkg;

  localparam int SIZE_RMT          = 32;
  localparam int SIZE_RMT_LOG      = 5;
  localparam int SIZE_PHYSICAL_LOG = 7;
  localparam int COMMIT_WIDTH      = 4;

  // Recovery read-out moves four entries per beat.
  localparam int BEAT_W    = SIZE_RMT_LOG - 2;
  localparam int NUM_BEATS = SIZE_RMT / 4;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WALK = 1'b1
  } amt_state_e;

endpackage

// File: rtl/amt_free_resolve.sv
// Combinational intra-group dependency resolution for a retire group.
// Slot 0 is oldest. For each slot it picks the physical tag that the slot's
// retirement releases, and marks which slots are the youngest writer of their
// logical register (only those update the table).
module amt_free_resolve
  import arch_map_table_pkg::*;
(
  input  logic [COMMIT_WIDTH-1:0]                        i_valid,
  input  logic [COMMIT_WIDTH-1:0][SIZE_RMT_LOG-1:0]      i_log,
  input  logic [COMMIT_WIDTH-1:0][SIZE_PHYSICAL_LOG-1:0] i_phy,
  input  logic [COMMIT_WIDTH-1:0][SIZE_PHYSICAL_LOG-1:0] i_old_tag,
  output logic [COMMIT_WIDTH-1:0][SIZE_PHYSICAL_LOG-1:0] o_free_reg,
  output logic [COMMIT_WIDTH-1:0]                        o_wr_mask
);

  // Released tag: youngest older slot with the same destination, else the table value.
  always_comb begin
    o_free_reg = i_old_tag;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
        if (j < k && i_valid[j] && i_log[j] == i_log[k]) begin
          o_free_reg[k] = i_phy[j];
        end
      end
    end
  end

  // Write mask: a slot writes only if no younger valid slot targets the same register.
  always_comb begin
    o_wr_mask = i_valid;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
        if (j > k && i_valid[j] && i_log[j] == i_log[k]) begin
          o_wr_mask[k] = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/arch_map_table.sv
// Architectural map table: retire-time mapping updates, physical register
// release, and a four-entries-per-beat read-out walk on pipeline recovery.
// Optional macro ARCH_MAP_FREE_OUTREG_EN registers the free outputs (1-cycle latency).
// Optional macro ARCH_MAP_HOLD_CHECK enables a simulation check that the commit
// stage honours busy_o.
// Handshake: there is no backpressure on retire. busy_o high means the commit
// stage must hold; any commitValid presented while busy_o is high is dropped
// (no table write, no free). recoverValid_o beats are unconditionally accepted.
module arch_map_table
  import arch_map_table_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         recoverFlag_i,
  input  logic                         commitValid0_i,
  input  logic                         commitValid1_i,
  input  logic                         commitValid2_i,
  input  logic                         commitValid3_i,
  input  logic [SIZE_RMT_LOG-1:0]      commitLogDest0_i,
  input  logic [SIZE_RMT_LOG-1:0]      commitLogDest1_i,
  input  logic [SIZE_RMT_LOG-1:0]      commitLogDest2_i,
  input  logic [SIZE_RMT_LOG-1:0]      commitLogDest3_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0] commitPhyDest0_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0] commitPhyDest1_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0] commitPhyDest2_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0] commitPhyDest3_i,
  output logic                         freeValid0_o,
  output logic                         freeValid1_o,
  output logic                         freeValid2_o,
  output logic                         freeValid3_o,
  output logic [SIZE_PHYSICAL_LOG-1:0] freeReg0_o,
  output logic [SIZE_PHYSICAL_LOG-1:0] freeReg1_o,
  output logic [SIZE_PHYSICAL_LOG-1:0] freeReg2_o,
  output logic [SIZE_PHYSICAL_LOG-1:0] freeReg3_o,
  output logic                         recoverValid_o,
  output logic [SIZE_RMT_LOG-3:0]      recoverIdx_o,
  output logic [SIZE_PHYSICAL_LOG-1:0] recoverPhy0_o,
  output logic [SIZE_PHYSICAL_LOG-1:0] recoverPhy1_o,
  output logic [SIZE_PHYSICAL_LOG-1:0] recoverPhy2_o,
  output logic [SIZE_PHYSICAL_LOG-1:0] recoverPhy3_o,
  output logic                         recoverDone_o,
  output logic                         busy_o,
  output amt_state_e                   dbg_state_o
);

  logic [SIZE_PHYSICAL_LOG-1:0]                  r_amt [SIZE_RMT];
  amt_state_e                                    r_state;
  amt_state_e                                    w_state_nxt;
  logic [BEAT_W-1:0]                             r_idx;
  logic [BEAT_W-1:0]                             w_idx_nxt;

  logic                                          w_commit_en;
  logic [COMMIT_WIDTH-1:0]                       w_raw_valid;
  logic [COMMIT_WIDTH-1:0]                       w_valid;
  logic [COMMIT_WIDTH-1:0][SIZE_RMT_LOG-1:0]      w_log;
  logic [COMMIT_WIDTH-1:0][SIZE_PHYSICAL_LOG-1:0] w_phy;
  logic [COMMIT_WIDTH-1:0][SIZE_PHYSICAL_LOG-1:0] w_old_tag;
  logic [COMMIT_WIDTH-1:0][SIZE_PHYSICAL_LOG-1:0] w_free_reg;
  logic [COMMIT_WIDTH-1:0][SIZE_PHYSICAL_LOG-1:0] w_free_gated;
  logic [COMMIT_WIDTH-1:0]                       w_wr_mask;
  logic [COMMIT_WIDTH-1:0]                       w_free_valid_out;
  logic [COMMIT_WIDTH-1:0][SIZE_PHYSICAL_LOG-1:0] w_free_reg_out;
  logic [COMMIT_WIDTH-1:0][SIZE_PHYSICAL_LOG-1:0] w_rphy;

  assign w_raw_valid = {commitValid3_i, commitValid2_i, commitValid1_i, commitValid0_i};
  assign w_log       = {commitLogDest3_i, commitLogDest2_i, commitLogDest1_i, commitLogDest0_i};
  assign w_phy       = {commitPhyDest3_i, commitPhyDest2_i, commitPhyDest1_i, commitPhyDest0_i};

  // Retire is honoured only while idle; the recoverFlag_i cycle itself still retires.
  assign w_commit_en = (r_state == ST_IDLE) && !reset;
  assign w_valid     = w_raw_valid & {COMMIT_WIDTH{w_commit_en}};

  // Pre-edge table lookup for each slot's destination.
  always_comb begin
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      w_old_tag[k] = r_amt[w_log[k]];
    end
  end

  amt_free_resolve u_resolve (
    .i_valid    (w_valid),
    .i_log      (w_log),
    .i_phy      (w_phy),
    .i_old_tag  (w_old_tag),
    .o_free_reg (w_free_reg),
    .o_wr_mask  (w_wr_mask)
  );

  // Free tags read as zero when their slot is not releasing anything.
  always_comb begin
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      w_free_gated[k] = w_valid[k] ? w_free_reg[k] : '0;
    end
  end

  // Table update: identity map on reset, youngest writer per register otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SIZE_RMT; i++) begin
        r_amt[i] <= SIZE_PHYSICAL_LOG'(i);
      end
    end else begin
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
        if (w_valid[k] && w_wr_mask[k]) begin
          r_amt[w_log[k]] <= w_phy[k];
        end
      end
    end
  end

  // Walk FSM state and beat counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Walk FSM next state: a flush during the walk restarts it from beat 0.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (recoverFlag_i) begin
          w_state_nxt = ST_WALK;
          w_idx_nxt   = '0;
        end
      end
      ST_WALK: begin
        if (recoverFlag_i) begin
          w_idx_nxt = '0;
        end else if (r_idx == LAST_BEAT) begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // Read-out of the four entries addressed by the current beat.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      w_rphy[n] = (r_state == ST_WALK) ? r_amt[{r_idx, n[1:0]}] : '0;
    end
  end

  assign busy_o         = (r_state == ST_WALK);
  assign dbg_state_o    = r_state;
  assign recoverValid_o = (r_state == ST_WALK);
  assign recoverIdx_o   = r_idx;
  // Done is withheld when a restart lands on the last beat: the walk is not over.
  assign recoverDone_o  = (r_state == ST_WALK) && (r_idx == LAST_BEAT) && !recoverFlag_i;
  assign recoverPhy0_o  = w_rphy[0];
  assign recoverPhy1_o  = w_rphy[1];
  assign recoverPhy2_o  = w_rphy[2];
  assign recoverPhy3_o  = w_rphy[3];

`ifdef ARCH_MAP_FREE_OUTREG_EN
  logic [COMMIT_WIDTH-1:0]                       r_free_valid;
  logic [COMMIT_WIDTH-1:0][SIZE_PHYSICAL_LOG-1:0] r_free_reg;

  // Registered frees; the flush cycle's frees still drain since they are retired.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_free_valid <= '0;
      r_free_reg   <= '0;
    end else begin
      r_free_valid <= w_valid;
      r_free_reg   <= w_free_gated;
    end
  end

  assign w_free_valid_out = r_free_valid;
  assign w_free_reg_out   = r_free_reg;
`else
  assign w_free_valid_out = w_valid;
  assign w_free_reg_out   = w_free_gated;
`endif

  assign freeValid0_o = w_free_valid_out[0];
  assign freeValid1_o = w_free_valid_out[1];
  assign freeValid2_o = w_free_valid_out[2];
  assign freeValid3_o = w_free_valid_out[3];
  assign freeReg0_o   = w_free_reg_out[0];
  assign freeReg1_o   = w_free_reg_out[1];
  assign freeReg2_o   = w_free_reg_out[2];
  assign freeReg3_o   = w_free_reg_out[3];

`ifdef ARCH_MAP_HOLD_CHECK
  // The commit stage must hold retire while the walk owns the table.
  a_hold_during_walk: assert property (@(posedge clk) disable iff (reset)
    (r_state == ST_WALK) |-> (w_raw_valid == '0))
    else $error("commit presented while busy_o high");
`endif

endmodule

// File: tb/tb_arch_map_table.sv
// Directed bench for arch_map_table; follows ARCH_MAP_FREE_OUTREG_EN for free latency.
module tb_arch_map_table;

  logic       clk;
  logic       reset;
  logic       recover_flag;
  logic [3:0] c_valid;
  logic [4:0] c_log [4];
  logic [6:0] c_phy [4];
  logic [3:0] fv;
  logic [6:0] fr [4];
  logic       rvalid;
  logic [2:0] ridx;
  logic [6:0] rphy [4];
  logic       rdone;
  logic       busy;
  logic       dbg_state;

  int checks;
  int failures;

  logic [6:0] walk_img [32];
  int         walk_beats;
  int         walk_done_idx;
  bit         walk_order_ok;

  logic [3:0] cap_fv;
  logic [6:0] cap_fr [4];

  arch_map_table dut (
    .clk              (clk),
    .reset            (reset),
    .recoverFlag_i    (recover_flag),
    .commitValid0_i   (c_valid[0]),
    .commitValid1_i   (c_valid[1]),
    .commitValid2_i   (c_valid[2]),
    .commitValid3_i   (c_valid[3]),
    .commitLogDest0_i (c_log[0]),
    .commitLogDest1_i (c_log[1]),
    .commitLogDest2_i (c_log[2]),
    .commitLogDest3_i (c_log[3]),
    .commitPhyDest0_i (c_phy[0]),
    .commitPhyDest1_i (c_phy[1]),
    .commitPhyDest2_i (c_phy[2]),
    .commitPhyDest3_i (c_phy[3]),
    .freeValid0_o     (fv[0]),
    .freeValid1_o     (fv[1]),
    .freeValid2_o     (fv[2]),
    .freeValid3_o     (fv[3]),
    .freeReg0_o       (fr[0]),
    .freeReg1_o       (fr[1]),
    .freeReg2_o       (fr[2]),
    .freeReg3_o       (fr[3]),
    .recoverValid_o   (rvalid),
    .recoverIdx_o     (ridx),
    .recoverPhy0_o    (rphy[0]),
    .recoverPhy1_o    (rphy[1]),
    .recoverPhy2_o    (rphy[2]),
    .recoverPhy3_o    (rphy[3]),
    .recoverDone_o    (rdone),
    .busy_o           (busy),
    .dbg_state_o      (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_commit();
    c_valid = 4'b0;
    for (int k = 0; k < 4; k++) begin
      c_log[k] = '0;
      c_phy[k] = '0;
    end
  endtask

  task automatic set_slot(input int k, input logic [4:0] lg, input logic [6:0] ph);
    c_valid[k] = 1'b1;
    c_log[k]   = lg;
    c_phy[k]   = ph;
  endtask

  // Presents the current commit group for one cycle and captures the frees it produces.
  // On return the edge has happened and commit/recover inputs are cleared.
  task automatic commit_and_capture();
`ifdef ARCH_MAP_FREE_OUTREG_EN
    step();
    clear_commit();
    recover_flag = 1'b0;
    cap_fv = fv;
    for (int k = 0; k < 4; k++) cap_fr[k] = fr[k];
`else
    #1;
    cap_fv = fv;
    for (int k = 0; k < 4; k++) cap_fr[k] = fr[k];
    step();
    clear_commit();
    recover_flag = 1'b0;
`endif
  endtask

  task automatic start_walk();
    recover_flag = 1'b1;
    step();
    recover_flag = 1'b0;
  endtask

  // Gathers beats until recoverValid drops (bounded); assumes the walk is at beat 0.
  task automatic collect_walk();
    walk_beats    = 0;
    walk_done_idx = -1;
    walk_order_ok = 1'b1;
    for (int i = 0; i < 32; i++) walk_img[i] = 7'h7f;
    for (int c = 0; c < 12; c++) begin
      if (!rvalid) break;
      if (int'(ridx) != walk_beats) walk_order_ok = 1'b0;
      for (int n = 0; n < 4; n++) walk_img[4*int'(ridx)+n] = rphy[n];
      if (rdone) walk_done_idx = int'(ridx);
      walk_beats++;
      step();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++;
    if (rvalid !== 1'b0 || rdone !== 1'b0) begin
      failures++; $display("FAIL reset_recover got valid=%0b done=%0b exp=0,0", rvalid, rdone);
    end
    checks++;
    if (fv !== 4'b0) begin failures++; $display("FAIL reset_free_valid got=%b exp=0000", fv); end
    checks++;
    if (dbg_state !== 1'b0 || rphy[0] !== 7'd0) begin
      failures++; $display("FAIL reset_state got state=%0b phy0=%0d exp=0,0", dbg_state, rphy[0]);
    end
  endtask

  task automatic test_identity_walk();
    step();
    step();
    start_walk();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL walk_busy got=%0b exp=1", busy); end
    collect_walk();
    checks++;
    if (walk_beats !== 8 || !walk_order_ok) begin
      failures++; $display("FAIL walk_beats got=%0d order_ok=%0b exp=8,1", walk_beats, walk_order_ok);
    end
    checks++;
    if (walk_done_idx !== 7) begin failures++; $display("FAIL walk_done got=%0d exp=7", walk_done_idx); end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (walk_img[i] !== 7'(i)) begin
        failures++; $display("FAIL identity_entry%0d got=%0d exp=%0d", i, walk_img[i], i);
      end
    end
    checks++;
    if (busy !== 1'b0 || rvalid !== 1'b0) begin
      failures++; $display("FAIL walk_end got busy=%0b valid=%0b exp=0,0", busy, rvalid);
    end
  endtask

  task automatic test_single_free();
    set_slot(0, 5'd3, 7'd40);
    commit_and_capture();
    checks++;
    if (cap_fv !== 4'b0001 || cap_fr[0] !== 7'd3) begin
      failures++; $display("FAIL single_free got valid=%b reg0=%0d exp=0001,3", cap_fv, cap_fr[0]);
    end
    start_walk();
    collect_walk();
    checks++;
    if (walk_img[3] !== 7'd40 || walk_img[4] !== 7'd4) begin
      failures++; $display("FAIL single_amt got e3=%0d e4=%0d exp=40,4", walk_img[3], walk_img[4]);
    end
  endtask

  task automatic test_same_dest();
    set_slot(1, 5'd5, 7'd50);
    set_slot(2, 5'd5, 7'd51);
    commit_and_capture();
    checks++;
    if (cap_fv !== 4'b0110) begin failures++; $display("FAIL same_dest_valid got=%b exp=0110", cap_fv); end
    checks++;
    if (cap_fr[1] !== 7'd5 || cap_fr[2] !== 7'd50) begin
      failures++; $display("FAIL same_dest_regs got r1=%0d r2=%0d exp=5,50", cap_fr[1], cap_fr[2]);
    end
    start_walk();
    collect_walk();
    checks++;
    if (walk_img[5] !== 7'd51 || walk_img[3] !== 7'd40) begin
      failures++; $display("FAIL same_dest_amt got e5=%0d e3=%0d exp=51,40", walk_img[5], walk_img[3]);
    end
  endtask

  task automatic test_recover_same_cycle();
    set_slot(0, 5'd1,  7'd60);
    set_slot(1, 5'd8,  7'd61);
    set_slot(2, 5'd9,  7'd62);
    set_slot(3, 5'd10, 7'd64);
    recover_flag = 1'b1;
    commit_and_capture();
    checks++;
    if (cap_fv !== 4'b1111) begin failures++; $display("FAIL recov_free_valid got=%b exp=1111", cap_fv); end
    checks++;
    if (cap_fr[0] !== 7'd1 || cap_fr[1] !== 7'd8 || cap_fr[2] !== 7'd9 || cap_fr[3] !== 7'd10) begin
      failures++;
      $display("FAIL recov_free_regs got %0d,%0d,%0d,%0d exp=1,8,9,10", cap_fr[0], cap_fr[1], cap_fr[2], cap_fr[3]);
    end
    checks++;
    if (rvalid !== 1'b1 || ridx !== 3'd0 || rphy[1] !== 7'd60) begin
      failures++; $display("FAIL recov_beat0 got valid=%0b idx=%0d e1=%0d exp=1,0,60", rvalid, ridx, rphy[1]);
    end
    collect_walk();
    checks++;
    if (walk_beats !== 8 || walk_img[8] !== 7'd61 || walk_img[10] !== 7'd64) begin
      failures++;
      $display("FAIL recov_walk got beats=%0d e8=%0d e10=%0d exp=8,61,64", walk_beats, walk_img[8], walk_img[10]);
    end
  endtask

  task automatic test_commit_during_walk();
    start_walk();
    set_slot(0, 5'd2, 7'd70);
    #1;
    checks++;
    if (fv[0] !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL walk_commit_free got valid0=%0b busy=%0b exp=0,1", fv[0], busy);
    end
    step();
    clear_commit();
    checks++;
    if (fv[0] !== 1'b0) begin failures++; $display("FAIL walk_commit_free_late got=%0b exp=0", fv[0]); end
    for (int c = 0; c < 12 && busy; c++) step();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL walk_commit_timeout got busy=%0b exp=0", busy); end
    start_walk();
    collect_walk();
    checks++;
    if (walk_img[2] !== 7'd2) begin failures++; $display("FAIL walk_commit_amt got e2=%0d exp=2", walk_img[2]); end
  endtask

  task automatic test_restart();
    start_walk();
    step();
    step();
    recover_flag = 1'b1;
    step();
    recover_flag = 1'b0;
    checks++;
    if (ridx !== 3'd0 || rvalid !== 1'b1) begin
      failures++; $display("FAIL restart_idx got idx=%0d valid=%0b exp=0,1", ridx, rvalid);
    end
    collect_walk();
    checks++;
    if (walk_beats !== 8 || walk_done_idx !== 7) begin
      failures++; $display("FAIL restart_walk got beats=%0d done=%0d exp=8,7", walk_beats, walk_done_idx);
    end
  endtask

  task automatic test_reset_mid_walk();
    start_walk();
    step();
    step();
    step();
    checks++;
    if (ridx !== 3'd3) begin failures++; $display("FAIL midwalk_idx got=%0d exp=3", ridx); end
    reset = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || rvalid !== 1'b0 || rdone !== 1'b0) begin
      failures++; $display("FAIL midwalk_reset got busy=%0b valid=%0b done=%0b exp=0,0,0", busy, rvalid, rdone);
    end
    reset = 1'b0;
    step();
    start_walk();
    collect_walk();
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (walk_img[i] !== 7'(i)) begin
        failures++; $display("FAIL midwalk_identity_e%0d got=%0d exp=%0d", i, walk_img[i], i);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks       = 0;
    failures     = 0;
    reset        = 1'b1;
    recover_flag = 1'b0;
    clear_commit();
    test_reset();
    test_identity_walk();
    test_single_free();
    test_same_dest();
    test_recover_same_cycle();
    test_commit_during_walk();
    test_restart();
    test_reset_mid_walk();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
